frame_shift_ctrl: RTL and testbench

Block-floating-point scaling controller. It sits directly upstream of the fixed bit-shift stage. It registers the sample stream through to the shifter and measures per-frame headroom, expressed as the minimum count of redundant sign bits. At each frame end it publishes the safe left-shift amount that the downstream shifter applies to the next frame.

---
 rtl/frame_shift_ctrl_pkg.sv | 29 ++
 rtl/frame_shift_ctrl_lead_sign_count.sv | 34 +++
 rtl/frame_shift_ctrl.sv | 165 ++++++++++++++++
 tb/tb_frame_shift_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/frame_shift_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : frame_shift_ctrl_pkg
// Brief    : Shared state encodings and constant helpers for the block
//            floating-point scaling controller.
// Revision : 1.0 - initial release
// ============================================================================
package frame_shift_ctrl_pkg;

  // Frame measurement FSM states
  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_MEASURE = 1'b1
  } state_t;

  // Ceiling log2 for sizing counters at elaboration time (value >= 2)
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < value) begin
        r = r + 1;
      end
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/frame_shift_ctrl_lead_sign_count.sv
`default_nettype none
// ============================================================================
// Module   : lead_sign_count
// Brief    : Combinational count of redundant sign bits, i.e. the number of
//            contiguous bits directly below the MSB that equal the MSB.
// Revision : 1.0 - initial release
// ============================================================================
module lead_sign_count
  import frame_shift_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int LEAD_WIDTH = clog2(DATA_WIDTH)
) (
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic [LEAD_WIDTH-1:0] o_lead
);

  logic w_run;

  // Walk down from MSB-1, counting until the first bit that differs from the sign
  always_comb begin
    w_run  = 1'b1;
    o_lead = '0;
    for (int i = DATA_WIDTH - 2; i >= 0; i--) begin
      if (w_run && (i_data[i] == i_data[DATA_WIDTH-1])) begin
        o_lead = o_lead + LEAD_WIDTH'(1);
      end else begin
        w_run = 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/frame_shift_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : frame_shift_ctrl
// Brief    : Block floating-point scaling controller. Registers the sample
//            stream through to the shifter, tracks the per-frame minimum of
//            redundant sign bits and publishes a clamped left-shift amount
//            at each frame end.
// Revision : 1.0 - initial release
// ============================================================================
module frame_shift_ctrl
  import frame_shift_ctrl_pkg::*;
#(
  parameter string ARCHITECTURE = "BEHAVIORAL",
  parameter int    DATA_WIDTH   = 8,
  parameter int    FRAME_LENGTH = 4,
  parameter int    MAX_SHIFT    = 4,
  parameter int    SHIFT_WIDTH  = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_WIDTH-1:0]  data_in,
  input  logic                   valid_in,
  input  logic                   sync_in,
  output logic [DATA_WIDTH-1:0]  data_out,
  output logic                   valid_out,
  output logic                   sync_out,
  output logic [SHIFT_WIDTH-1:0] shift_out,
  output logic                   shift_valid,
  output logic                   frame_err
);

  localparam int CNT_WIDTH  = clog2(FRAME_LENGTH);
  localparam int LEAD_WIDTH = clog2(DATA_WIDTH);

  localparam logic [CNT_WIDTH-1:0]  c_last_count = CNT_WIDTH'(FRAME_LENGTH - 1);
  localparam logic [LEAD_WIDTH-1:0] c_min_init   = LEAD_WIDTH'(DATA_WIDTH - 1);
  localparam logic [LEAD_WIDTH-1:0] c_max_shift  = LEAD_WIDTH'(MAX_SHIFT);

  generate
    if (ARCHITECTURE == "BEHAVIORAL") begin : g_behavioral

      state_t                r_state;
      state_t                w_state_nxt;
      logic [CNT_WIDTH-1:0]  r_count;
      logic [CNT_WIDTH-1:0]  w_count_nxt;
      logic [LEAD_WIDTH-1:0] r_min;
      logic [LEAD_WIDTH-1:0] w_min_nxt;
      logic [LEAD_WIDTH-1:0] w_lead;
      logic [LEAD_WIDTH-1:0] w_min_acc;
      logic [LEAD_WIDTH-1:0] w_shift_clamp;
      logic                  w_shift_upd;
      logic                  w_err;
      logic                  w_sync;

      lead_sign_count #(
        .DATA_WIDTH (DATA_WIDTH),
        .LEAD_WIDTH (LEAD_WIDTH)
      ) u_lead_sign_count (
        .i_data (data_in),
        .o_lead (w_lead)
      );

      assign w_sync = valid_in & sync_in;

      // Running minimum including the current sample, and its clamped shift
      always_comb begin
        w_min_acc     = (w_lead < r_min) ? w_lead : r_min;
        w_shift_clamp = (w_min_acc > c_max_shift) ? c_max_shift : w_min_acc;
      end

      // Next-state logic: frame start, accumulation, frame end and short-frame restart
      always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_min_nxt   = r_min;
        w_shift_upd = 1'b0;
        w_err       = 1'b0;
        case (r_state)
          ST_IDLE: begin
            if (w_sync) begin
              w_state_nxt = ST_MEASURE;
              w_count_nxt = CNT_WIDTH'(1);
              w_min_nxt   = w_lead;
            end
          end
          ST_MEASURE: begin
            if (w_sync) begin
              // A sync before completion wins even on the would-be last sample
              w_err       = 1'b1;
              w_count_nxt = CNT_WIDTH'(1);
              w_min_nxt   = w_lead;
            end else if (valid_in) begin
              if (r_count == c_last_count) begin
                w_shift_upd = 1'b1;
                w_state_nxt = ST_IDLE;
                w_count_nxt = '0;
                w_min_nxt   = c_min_init;
              end else begin
                w_count_nxt = r_count + CNT_WIDTH'(1);
                w_min_nxt   = w_min_acc;
              end
            end
          end
          default: begin
            w_state_nxt = ST_IDLE;
            w_count_nxt = '0;
            w_min_nxt   = c_min_init;
          end
        endcase
      end

      // FSM, sample counter and running-minimum registers
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_state <= ST_IDLE;
          r_count <= '0;
          r_min   <= c_min_init;
        end else begin
          r_state <= w_state_nxt;
          r_count <= w_count_nxt;
          r_min   <= w_min_nxt;
        end
      end

      // Fixed one-cycle pass-through of the sample stream
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          data_out  <= '0;
          valid_out <= 1'b0;
          sync_out  <= 1'b0;
        end else begin
          data_out  <= data_in;
          valid_out <= valid_in;
          sync_out  <= w_sync;
        end
      end

      // Publish shift amount and status pulses; shift_out holds between frame ends
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          shift_out   <= '0;
          shift_valid <= 1'b0;
          frame_err   <= 1'b0;
        end else begin
          shift_valid <= w_shift_upd;
          frame_err   <= w_err;
          if (w_shift_upd) begin
            shift_out <= SHIFT_WIDTH'(w_shift_clamp);
          end
        end
      end

    end else begin : g_placeholder
      // Device-specific implementations are not provided; outputs are tied off
      assign data_out    = '0;
      assign valid_out   = 1'b0;
      assign sync_out    = 1'b0;
      assign shift_out   = '0;
      assign shift_valid = 1'b0;
      assign frame_err   = 1'b0;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_frame_shift_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_frame_shift_ctrl
// Brief    : Directed, table-driven testbench for frame_shift_ctrl (8/4/4/3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_frame_shift_ctrl;

  logic       clk;
  logic       rst;
  logic [7:0] data_in;
  logic       valid_in;
  logic       sync_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       sync_out;
  logic [2:0] shift_out;
  logic       shift_valid;
  logic       frame_err;

  int   total;
  int   bad;
  int   sv_seen;
  int   err_seen;
  logic last_sv;
  logic last_err;

  typedef struct packed {
    logic [3:0][7:0] d;
    logic [2:0]      exp;
  } vec_t;

  vec_t tbl [7];

  frame_shift_ctrl #(
    .ARCHITECTURE ("BEHAVIORAL"),
    .DATA_WIDTH   (8),
    .FRAME_LENGTH (4),
    .MAX_SHIFT    (4),
    .SHIFT_WIDTH  (3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .data_in     (data_in),
    .valid_in    (valid_in),
    .sync_in     (sync_in),
    .data_out    (data_out),
    .valid_out   (valid_out),
    .sync_out    (sync_out),
    .shift_out   (shift_out),
    .shift_valid (shift_valid),
    .frame_err   (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] c, input logic [7:0] e,
                              input logic [2:0] x);
    vec_t v;
    v.d[0] = a;
    v.d[1] = b;
    v.d[2] = c;
    v.d[3] = e;
    v.exp  = x;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle, then check the 1-cycle pass-through just after the edge
  task send(input logic [7:0] d, input logic v, input logic s);
    data_in  = d;
    valid_in = v;
    sync_in  = s;
    @(posedge clk);
    #1;
    chk("data_out", {24'd0, data_out}, {24'd0, d});
    chk("valid_out", {31'd0, valid_out}, {31'd0, v});
    chk("sync_out", {31'd0, sync_out}, {31'd0, (s & v)});
    if (shift_valid) sv_seen++;
    if (frame_err) err_seen++;
    last_sv  = shift_valid;
    last_err = frame_err;
  endtask

  task idle_cycle();
    send(8'($urandom), 1'b0, 1'($urandom));
  endtask

  task run_frame(input vec_t v);
    for (int i = 0; i < 4; i++) begin
      send(v.d[i], 1'b1, (i == 0));
    end
  endtask

  task chk_all_zero(input string tag);
    chk({tag, "_data_out"}, {24'd0, data_out}, 32'd0);
    chk({tag, "_valid_out"}, {31'd0, valid_out}, 32'd0);
    chk({tag, "_sync_out"}, {31'd0, sync_out}, 32'd0);
    chk({tag, "_shift_out"}, {29'd0, shift_out}, 32'd0);
    chk({tag, "_shift_valid"}, {31'd0, shift_valid}, 32'd0);
    chk({tag, "_frame_err"}, {31'd0, frame_err}, 32'd0);
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    sv_seen  = 0;
    err_seen = 0;
    last_sv  = 1'b0;
    last_err = 1'b0;
    rst      = 1'b0;
    data_in  = 8'h00;
    valid_in = 1'b0;
    sync_in  = 1'b0;

    tbl[0] = mk(8'h03, 8'hFE, 8'h01, 8'h00, 3'd4);
    tbl[1] = mk(8'hE0, 8'h10, 8'h08, 8'h00, 3'd2);
    tbl[2] = mk(8'h40, 8'h00, 8'h00, 8'h00, 3'd0);
    tbl[3] = mk(8'h80, 8'h7F, 8'h00, 8'h00, 3'd0);
    tbl[4] = mk(8'hFF, 8'hFF, 8'hFF, 8'hFF, 3'd4);
    tbl[5] = mk(8'h00, 8'h00, 8'h00, 8'h00, 3'd4);
    tbl[6] = mk(8'h1F, 8'hF0, 8'hE0, 8'h3F, 3'd1);

    // Reset state
    #2 rst = 1'b1;
    #1 chk_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Samples before the first sync are ignored
    sv_seen = 0;
    for (int i = 0; i < 6; i++) send(8'($urandom), 1'b1, 1'b0);
    chk("presync_shift_valid_count", sv_seen, 0);
    chk("presync_shift_out", {29'd0, shift_out}, 32'd0);

    // Table of complete frames
    for (int k = 0; k < 7; k++) begin
      sv_seen  = 0;
      err_seen = 0;
      run_frame(tbl[k]);
      chk($sformatf("tbl%0d_shift_valid_on_last", k), {31'd0, last_sv}, 32'd1);
      chk($sformatf("tbl%0d_shift_out", k), {29'd0, shift_out}, {29'd0, tbl[k].exp});
      idle_cycle();
      chk($sformatf("tbl%0d_shift_valid_pulse_end", k), {31'd0, shift_valid}, 32'd0);
      chk($sformatf("tbl%0d_shift_valid_count", k), sv_seen, 1);
      chk($sformatf("tbl%0d_frame_err_count", k), err_seen, 0);
      chk($sformatf("tbl%0d_shift_out_hold", k), {29'd0, shift_out}, {29'd0, tbl[k].exp});
    end

    // Gapped frame: same result as the contiguous one
    sv_seen  = 0;
    err_seen = 0;
    for (int i = 0; i < 4; i++) begin
      send(tbl[1].d[i], 1'b1, (i == 0));
      if (i < 3) begin
        for (int g = 0; g < 3; g++) idle_cycle();
      end
    end
    chk("gap_shift_valid_on_last", {31'd0, last_sv}, 32'd1);
    chk("gap_shift_out", {29'd0, shift_out}, 32'd2);
    chk("gap_shift_valid_count", sv_seen, 1);

    // Sync on 3rd sample: error, shift held, restarted frame 40,00,00,00 -> 0
    sv_seen  = 0;
    err_seen = 0;
    send(8'h00, 1'b1, 1'b1);
    send(8'h00, 1'b1, 1'b0);
    send(8'h40, 1'b1, 1'b1);
    chk("short_frame_err", {31'd0, last_err}, 32'd1);
    chk("short_shift_held", {29'd0, shift_out}, 32'd2);
    send(8'h00, 1'b1, 1'b0);
    send(8'h00, 1'b1, 1'b0);
    chk("short_no_early_update", sv_seen, 0);
    send(8'h00, 1'b1, 1'b0);
    chk("short_restart_shift_valid", {31'd0, last_sv}, 32'd1);
    chk("short_restart_shift_out", {29'd0, shift_out}, 32'd0);
    chk("short_err_count", err_seen, 1);

    // Sync coincident with the frame-end sample: error wins, no update
    run_frame(tbl[4]);
    chk("coinc_setup_shift_out", {29'd0, shift_out}, 32'd4);
    sv_seen  = 0;
    err_seen = 0;
    send(8'h00, 1'b1, 1'b1);
    send(8'h00, 1'b1, 1'b0);
    send(8'h00, 1'b1, 1'b0);
    send(8'h20, 1'b1, 1'b1);
    chk("coinc_frame_err", {31'd0, last_err}, 32'd1);
    chk("coinc_no_shift_valid", {31'd0, last_sv}, 32'd0);
    chk("coinc_shift_held", {29'd0, shift_out}, 32'd4);
    send(8'h00, 1'b1, 1'b0);
    send(8'h00, 1'b1, 1'b0);
    send(8'h00, 1'b1, 1'b0);
    chk("coinc_restart_shift_out", {29'd0, shift_out}, 32'd1);
    chk("coinc_shift_valid_count", sv_seen, 1);
    chk("coinc_err_count", err_seen, 1);

    // Asynchronous reset mid-frame with shift_out=2
    run_frame(tbl[1]);
    chk("arst_setup_shift_out", {29'd0, shift_out}, 32'd2);
    send(8'hE0, 1'b1, 1'b1);
    send(8'h10, 1'b1, 1'b0);
    #2 rst = 1'b1;
    #1 chk_all_zero("arst");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    sv_seen  = 0;
    err_seen = 0;
    for (int i = 0; i < 6; i++) send(8'h00, 1'b1, 1'b0);
    chk("arst_ignored_shift_valid", sv_seen, 0);
    chk("arst_ignored_frame_err", err_seen, 0);
    chk("arst_ignored_shift_out", {29'd0, shift_out}, 32'd0);
    run_frame(tbl[0]);
    chk("arst_after_frame_shift_out", {29'd0, shift_out}, 32'd4);
    chk("arst_after_frame_shift_valid", sv_seen, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
